// File: rtl/cube_if.sv
// cube_if: requester handshakes and cube-unit signals shared by cube_arbiter and its environment
interface cube_if;
    logic       req0;
    logic       req1;
    logic [1:0] x0;
    logic [1:0] x1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [5:0] result0;
    logic [5:0] result1;
    logic       err0;
    logic       err1;
    logic       cu_start;
    logic [1:0] cu_x;
    logic       cu_finish;
    logic [5:0] cu_result;
    logic       busy;

    // arbiter side
    modport slave (
        input  req0, req1, x0, x1, cu_finish, cu_result,
        output gnt0, gnt1, done0, done1, result0, result1, err0, err1, cu_start, cu_x, busy
    );

    // requesters plus cube unit side
    modport master (
        output req0, req1, x0, x1, cu_finish, cu_result,
        input  gnt0, gnt1, done0, done1, result0, result1, err0, err1, cu_start, cu_x, busy
    );
endinterface

// File: rtl/cube_arbiter.sv
// cube_arbiter: round-robin sharing of one sequential cube unit between two requesters, with timeout
module cube_arbiter #(
    parameter int TIMEOUT_CYC = 15
) (
    input logic   clk,
    input logic   rst,
    cube_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [5:0] LAST_CNT = 6'(TIMEOUT_CYC - 1);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       err_q, err_d;
    logic [1:0] cu_x_q, cu_x_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] res_q, res_d;
    logic       any_req;
    logic       pick;

    assign any_req = bus.req0 | bus.req1;
    // on a tie the requester not served last wins, otherwise whoever asks
    assign pick = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

    // state and datapath registers; last_grant resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            cu_x_q  <= 2'd0;
            cnt_q   <= 6'd0;
            res_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cu_x_q  <= cu_x_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // next state: a finish seen on the last WAIT cycle beats the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = any_req ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = (bus.cu_finish || cnt_q == LAST_CNT) ? RESP : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // datapath: latch owner/operand, count WAIT cycles, capture result or force a timeout response
    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        cu_x_d  = cu_x_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        if (state_q == IDLE && any_req) begin
            owner_d = pick;
            cu_x_d  = pick ? bus.x1 : bus.x0;
        end
        if (state_q == ISSUE) cnt_d = 6'd0;
        if (state_q == WAIT) begin
            cnt_d = cnt_q + 6'd1;
            res_d = bus.cu_finish ? bus.cu_result : 6'd0;
            err_d = ~bus.cu_finish;
        end
        if (state_q == RESP) last_d = owner_q;
    end

    // outputs decoded from state so the response fields read zero everywhere but the owner's RESP cycle
    always_comb begin
        bus.busy     = state_q != IDLE;
        bus.gnt0     = state_q != IDLE && !owner_q;
        bus.gnt1     = state_q != IDLE && owner_q;
        bus.done0    = state_q == RESP && !owner_q;
        bus.done1    = state_q == RESP && owner_q;
        bus.result0  = (state_q == RESP && !owner_q) ? res_q : 6'd0;
        bus.result1  = (state_q == RESP && owner_q) ? res_q : 6'd0;
        bus.err0     = state_q == RESP && !owner_q && err_q;
        bus.err1     = state_q == RESP && owner_q && err_q;
        bus.cu_start = state_q == ISSUE;
        bus.cu_x     = cu_x_q;
    end
endmodule

// File: tb/tb_cube_arbiter.sv
// tb_cube_arbiter: randomized scoreboard bench for cube_arbiter with a cube-unit model
module tb_cube_arbiter;
    localparam int TO = 15;

    typedef struct {
        logic       who;
        logic [5:0] res;
        logic       err;
        int         delay;
    } exp_t;

    typedef struct {
        logic       early;
        int         d;
        logic [1:0] x;
    } lat_t;

    typedef struct {
        logic       who;
        logic [1:0] x;
    } iss_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    cube_if bus();

    cube_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    lat_t lq[$];
    iss_t xq[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cnt = 0;
    logic last_m = 1'b1;
    logic gnt1_seen = 1'b0;
    logic stray = 1'b0;
    lat_t cur;
    int   t = 0;
    logic active = 1'b0;
    logic [1:0] rp, ra, rb;
    int   dc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] cube(input logic [1:0] x);
        int v;
        v = x;
        return 6'(v * v * v);
    endfunction

    // reference: the unit answers d cycles after cu_start; only answers inside the WAIT window count
    function automatic exp_t predict(input logic who, input logic [1:0] x, input int d);
        exp_t e;
        e.who = who;
        if (d >= 1 && d <= TO) begin
            e.res = cube(x);
            e.err = 1'b0;
            e.delay = d + 1;
        end else begin
            e.res = 6'd0;
            e.err = 1'b1;
            e.delay = TO + 1;
        end
        return e;
    endfunction

    task automatic push_op(input logic who, input logic [1:0] x, input logic early, input int d);
        iss_t i;
        lat_t l;
        i.who = who;
        i.x = x;
        l.early = early;
        l.d = d;
        l.x = x;
        xq.push_back(i);
        lq.push_back(l);
        sb.push_back(predict(who, x, d));
    endtask

    task automatic serve(input logic r0, input logic r1, input logic [1:0] a0, input logic [1:0] a1,
                         input int d0, input int d1, input logic e0, input logic e1);
        logic w;
        w = (r0 && r1) ? ~last_m : r1;
        push_op(w, w ? a1 : a0, w ? e1 : e0, w ? d1 : d0);
        if (r0 && r1) push_op(~w, w ? a0 : a1, w ? e0 : e1, w ? d0 : d1);
        last_m = (r0 && r1) ? ~w : w;
        @(negedge clk);
        bus.x0 = a0;
        bus.x1 = a1;
        bus.req0 = r0;
        bus.req1 = r1;
        for (int i = 0; i < 200 && (bus.req0 || bus.req1); i++) begin
            @(negedge clk);
            if (bus.done0) bus.req0 = 1'b0;
            if (bus.done1) bus.req1 = 1'b0;
        end
        check("serve_complete", {bus.req0, bus.req1}, 0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
    endtask

    // cube unit model: optional stale pulse in ISSUE, real answer d cycles after cu_start
    initial begin
        bus.cu_finish = 1'b0;
        bus.cu_result = 6'd0;
        forever begin
            @(negedge clk);
            bus.cu_finish = 1'b0;
            bus.cu_result = 6'd0;
            if (stray) begin
                bus.cu_finish = 1'b1;
                bus.cu_result = 6'd27;
                stray = 1'b0;
            end else if (bus.cu_start && lq.size() > 0) begin
                cur = lq.pop_front();
                t = 0;
                active = 1'b1;
                if (cur.early) begin
                    bus.cu_finish = 1'b1;
                    bus.cu_result = 6'h3f;
                end
            end else if (active) begin
                t++;
                if (t == cur.d) begin
                    bus.cu_finish = 1'b1;
                    bus.cu_result = cube(cur.x);
                    active = 1'b0;
                end else if (t > TO) begin
                    active = 1'b0;
                end
            end
        end
    end

    // monitor: invariants every cycle, operand check at cu_start, scoreboard pop at done
    initial begin
        iss_t it;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("gnt_exclusive", bus.gnt0 && bus.gnt1, 0);
                check("busy_vs_gnt", bus.busy, bus.gnt0 | bus.gnt1);
                check("quiet0", !bus.done0 && (bus.result0 != 0 || bus.err0), 0);
                check("quiet1", !bus.done1 && (bus.result1 != 0 || bus.err1), 0);
                if (bus.gnt1) gnt1_seen = 1'b1;
                if (bus.cu_start) begin
                    check("start_expected", xq.size() > 0, 1);
                    if (xq.size() > 0) begin
                        it = xq.pop_front();
                        check("cu_x", bus.cu_x, it.x);
                        check("start_gnt", it.who ? bus.gnt1 : bus.gnt0, 1);
                        start_cyc = cyc;
                    end
                end
                if (bus.done0 || bus.done1) begin
                    done_cnt++;
                    check("done_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("done_owner", bus.done1, e.who);
                        check("result", e.who ? bus.result1 : bus.result0, e.res);
                        check("err", e.who ? bus.err1 : bus.err0, e.err);
                        check("latency", cyc - start_cyc, e.delay);
                    end
                end
            end
        end
    end

    initial begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.x0 = 2'd0;
        bus.x1 = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_gnt", {bus.gnt0, bus.gnt1}, 0);
        check("rst_done", {bus.done0, bus.done1}, 0);
        check("rst_result", {bus.result0, bus.result1}, 0);
        check("rst_err", {bus.err0, bus.err1}, 0);
        check("rst_cu_start", bus.cu_start, 0);
        check("rst_cu_x", bus.cu_x, 0);
        rst = 1'b0;
        gnt1_seen = 1'b0;
        serve(1, 0, 2'd2, 2'd0, 3, 0, 0, 0);
        check("gnt1_never", gnt1_seen, 0);
        serve(1, 1, 2'd3, 2'd1, 2, 2, 0, 0);
        serve(1, 1, 2'd3, 2'd1, 2, 2, 0, 0);
        serve(0, 1, 2'd0, 2'd3, 0, 0, 0, 0);
        serve(1, 0, 2'd1, 2'd0, TO, 0, 0, 0);
        serve(0, 1, 2'd0, 2'd2, 0, 4, 0, 1);
        serve(1, 0, 2'd3, 2'd0, TO + 1, 0, 0, 0);
        serve(1, 1, 2'd2, 2'd3, 1, TO, 1, 0);
        for (int n = 0; n < 40; n++) begin
            rp = 2'($urandom_range(1, 3));
            ra = 2'($urandom);
            rb = 2'($urandom);
            serve(rp[0], rp[1], ra, rb, $urandom_range(0, TO + 1), $urandom_range(0, TO + 1),
                  1'($urandom), 1'($urandom));
        end
        @(negedge clk);
        bus.x0 = 2'd2;
        bus.req0 = 1'b1;
        begin
            iss_t i;
            lat_t l;
            i.who = 1'b0;
            i.x = 2'd2;
            l.early = 1'b0;
            l.d = 0;
            l.x = 2'd2;
            xq.push_back(i);
            lq.push_back(l);
        end
        for (int i = 0; i < 20 && !bus.cu_start; i++) @(negedge clk);
        check("abort_started", bus.cu_start, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_gnt", {bus.gnt0, bus.gnt1}, 0);
        check("abort_done", {bus.done0, bus.done1}, 0);
        check("abort_cu", {bus.cu_start, bus.cu_x}, 0);
        rst = 1'b0;
        last_m = 1'b1;
        repeat (3) @(negedge clk);
        dc = done_cnt;
        stray = 1'b1;
        repeat (5) @(negedge clk);
        check("stray_no_done", done_cnt, dc);
        check("stray_idle", bus.busy, 0);
        serve(1, 1, 2'd1, 2'd2, 5, 6, 0, 0);
        check("sb_drained", sb.size(), 0);
        check("issue_drained", xq.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/cube_arbiter.md
CUBE_ARBITER -- requirements
Module: cube_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 15, number of WAIT-state cycles allowed for cu_finish before abort (legal range 2..63).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0  input  1  requester 0 operation request, level, held until done0.
REQ-005 x0  input  2  requester 0 operand, stable while req0 high.
REQ-006 gnt0  output  1  requester 0 owns the cube unit.
REQ-007 done0  output  1  one-cycle completion pulse to requester 0.
REQ-008 result0  output  6  x0 cubed, valid only while done0 high.
REQ-009 err0  output  1  timeout flag, valid only while done0 high.
REQ-010 req1, x1, gnt1, done1, result1, err1: same widths and meaning as requester 0.
REQ-011 cu_start  output  1  one-cycle start pulse to the sequential cube unit.
REQ-012 cu_x  output  2  operand to the cube unit, held stable from ISSUE through WAIT.
REQ-013 cu_finish  input  1  cube unit completion pulse.
REQ-014 cu_result  input  6  cube unit result, valid while cu_finish high.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL use four states: IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: if any req is high, pick the owner, latch its x into cu_x, and go to ISSUE; otherwise stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: with both reqs high, grant the requester not served last; last_grant resets to 1, so req0 wins the first tie.
REQ-019 ISSUE: cu_start=1 for exactly this one cycle; go to WAIT; cu_finish sampled in ISSUE is ignored as stale.
REQ-020 WAIT: a 6-bit counter starts at 0 and increments each cycle; cu_finish=1 captures cu_result and goes to RESP with err=0.
REQ-021 WAIT timeout: if the counter reaches TIMEOUT_CYC-1 with no cu_finish, go to RESP with err=1 and result forced to 6'd0.
REQ-022 If cu_finish and timeout occur in the same cycle, cu_finish wins (err=0, result captured).
REQ-023 RESP: owner's done=1 for exactly one cycle with result and err; last_grant := owner; return to IDLE.
REQ-024 The owner's gnt SHALL be high in ISSUE, WAIT and RESP, and low in IDLE; never are both gnts high at once.
REQ-025 Non-owner done, result and err SHALL be 0; owner result and err SHALL be 0 outside RESP.
REQ-026 Latency: done pulses exactly 1 cycle after cu_finish is sampled; a request sampled in IDLE at edge k gives cu_start in cycle k+1.
REQ-027 If req drops mid-operation, the operation SHALL complete and done SHALL still pulse.
REQ-028 A req still high in the IDLE cycle after RESP SHALL count as a new request, subject to round-robin.
REQ-029 Operand width rule: cu_x = latched x[1:0] zero-extended; the result is passed through unmodified (legal values 0, 1, 8, 27).

Reset
REQ-030 With rst high at an edge, state=IDLE, last_grant=1, counter=0, and every output (gnt*, done*, result*, err*, cu_start, cu_x, busy) SHALL be 0 from the next cycle.
REQ-031 Reset asserted in any state, including mid-WAIT, SHALL abort the operation with no done pulse; a late cu_finish arriving in IDLE SHALL be ignored.

Verification
REQ-032 Single request: req0=1, x0=2'b10, model returns cu_finish 3 cycles after cu_start with 6'd8 -> cu_start one cycle, cu_x=2, done0 pulse with result0=8, err0=0, gnt1 never high.
REQ-033 Tie: req0=req1=1 from reset, x0=3, x1=1 -> first service to 0 (result0=27), then to 1 (result1=1); repeat the tie -> order stays alternating 0,1,0,1.
REQ-034 Timeout: req1=1, x1=3, model never asserts cu_finish, TIMEOUT_CYC=15 -> done1 exactly 15 WAIT cycles after ISSUE, err1=1, result1=0.
REQ-035 Boundary: cu_finish on the last WAIT cycle -> err=0 with the result captured; cu_finish pulsed during ISSUE -> ignored, unit still awaited.
REQ-036 Reset mid-WAIT: rst=1 two cycles after cu_start -> all outputs 0 next cycle, no done; a later stray cu_finish -> no response.
